// File: rtl/baseline_calc.sv
// Trigger baseline calculator.
// After reset (or a RECALC request in DONE) it accepts 2^CALC_LEN_LOG2 stream beats, sums every
// MSB-justified signed sample through a 2-stage pipeline and publishes the floor-rounded mean
// as BASELINE together with the level flag BL_CALC_COMP.
module baseline_calc #(
    parameter int ADC_RESOLUTION_WIDTH = 12,
    parameter int S_AXIS_TDATA_WIDTH   = 128,
    parameter int CALC_LEN_LOG2        = 28
) (
    input  logic                            AXIS_ACLK,
    input  logic                            AXIS_ARESETN,
    input  logic [S_AXIS_TDATA_WIDTH-1:0]   S_AXIS_TDATA,
    input  logic                            S_AXIS_TVALID,
    output logic                            S_AXIS_TREADY,
    input  logic                            RECALC,
    output logic [ADC_RESOLUTION_WIDTH-1:0] BASELINE,
    output logic                            BL_CALC_COMP
);

    localparam int SPB      = S_AXIS_TDATA_WIDTH / 16;
    localparam int SPB_LOG2 = $clog2(SPB);
    localparam int SUM_W    = ADC_RESOLUTION_WIDTH + SPB_LOG2;
    localparam int ACC_W    = SUM_W + CALC_LEN_LOG2;
    localparam int SHIFT    = CALC_LEN_LOG2 + SPB_LOG2;
    localparam int LSB_PAD  = 16 - ADC_RESOLUTION_WIDTH;

    typedef enum logic [1:0] {StIdle, StCalc, StDrain, StDone} state_e;

    state_e                    state;
    logic [CALC_LEN_LOG2-1:0]  beat_cnt;
    logic                      drain_cnt;
    logic                      s1_valid;
    logic signed [SUM_W-1:0]   s1_sum;
    logic signed [ACC_W-1:0]   acc;
    logic signed [SUM_W-1:0]   lane_sum;
    logic signed [ACC_W-1:0]   acc_shifted;
    logic                      accept;
    logic                      unused_tdata;

    // Justification padding below each sample carries no information.
    assign unused_tdata = ^S_AXIS_TDATA;

    assign accept      = S_AXIS_TVALID && S_AXIS_TREADY && (state == StCalc);
    assign acc_shifted = acc >>> SHIFT;

    // Sign-extended sum of all samples in the current beat.
    always_comb begin
        lane_sum = '0;
        for (int j = 0; j < SPB; j++) begin
            lane_sum = lane_sum + SUM_W'(signed'(
                S_AXIS_TDATA[16*j+LSB_PAD +: ADC_RESOLUTION_WIDTH]));
        end
    end

    // Control FSM, pipeline stages and registered outputs.
    always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
        if (!AXIS_ARESETN) begin
            state         <= StIdle;
            S_AXIS_TREADY <= 1'b0;
            BASELINE      <= '0;
            BL_CALC_COMP  <= 1'b0;
            beat_cnt      <= '0;
            drain_cnt     <= 1'b0;
            s1_valid      <= 1'b0;
            s1_sum        <= '0;
            acc           <= '0;
        end else begin
            // Stage 1 registers the beat sum, stage 2 folds it into the accumulator.
            s1_valid <= accept;
            if (accept) begin
                s1_sum <= lane_sum;
            end
            if (s1_valid) begin
                acc <= acc + ACC_W'(s1_sum);
            end

            // Clears below are placed after the stage-2 update so they take priority.
            unique case (state)
                StIdle: begin
                    state         <= StCalc;
                    S_AXIS_TREADY <= 1'b1;
                    beat_cnt      <= '0;
                    acc           <= '0;
                end
                StCalc: begin
                    if (accept) begin
                        beat_cnt <= beat_cnt + CALC_LEN_LOG2'(1);
                        if (beat_cnt == '1) begin
                            state         <= StDrain;
                            S_AXIS_TREADY <= 1'b0;
                            drain_cnt     <= 1'b0;
                        end
                    end
                end
                StDrain: begin
                    drain_cnt <= 1'b1;
                    // acc already holds the last beat's sum on the second drain cycle.
                    if (drain_cnt) begin
                        state        <= StDone;
                        BASELINE     <= acc_shifted[ADC_RESOLUTION_WIDTH-1:0];
                        BL_CALC_COMP <= 1'b1;
                    end
                end
                StDone: begin
                    if (RECALC) begin
                        state         <= StCalc;
                        S_AXIS_TREADY <= 1'b1;
                        BL_CALC_COMP  <= 1'b0;
                        beat_cnt      <= '0;
                        acc           <= '0;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_baseline_calc.sv
// Bench for baseline_calc with 4-beat calculations: a driver issues runs and pushes the
// expected mean into a scoreboard; a monitor pops and checks on each BL_CALC_COMP rise.
module tb_baseline_calc;

    localparam int NBEATS = 4;
    localparam int SPB    = 8;
    localparam int NSAMP  = NBEATS * SPB;

    logic         clk;
    logic         rst_n;
    logic [127:0] tdata;
    logic         tvalid;
    logic         tready;
    logic         recalc;
    logic [11:0]  baseline;
    logic         comp;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int accepts = 0;
    int tready_cycles = 0;
    int last_acc_cyc = 0;
    int rises = 0;
    logic prev_comp = 1'b0;
    logic [11:0] sb[$];
    logic [11:0] mon_exp;
    logic        hold_valid = 1'b0;
    logic [11:0] hold_exp = '0;
    int          last_expected = 0;
    int          cur[NSAMP];

    baseline_calc #(
        .ADC_RESOLUTION_WIDTH(12),
        .S_AXIS_TDATA_WIDTH(128),
        .CALC_LEN_LOG2(2)
    ) dut (
        .AXIS_ACLK(clk),
        .AXIS_ARESETN(rst_n),
        .S_AXIS_TDATA(tdata),
        .S_AXIS_TVALID(tvalid),
        .S_AXIS_TREADY(tready),
        .RECALC(recalc),
        .BASELINE(baseline),
        .BL_CALC_COMP(comp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, got, got, want, want);
        end
    endtask

    // Cycle, accept and ready bookkeeping (pre-edge values).
    always @(posedge clk) begin
        cyc++;
        if (rst_n && tready) tready_cycles++;
        if (rst_n && tvalid && tready) begin
            accepts++;
            last_acc_cyc = cyc;
        end
    end

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (rst_n) begin
            if (comp && !prev_comp) begin
                rises++;
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_comp: got rise, want none (baseline 0x%0h)", baseline);
                end else begin
                    mon_exp = sb.pop_front();
                    check("baseline", {20'd0, baseline}, {20'd0, mon_exp});
                    check("comp_latency", cyc - last_acc_cyc, 2);
                end
            end
            if (hold_valid && !comp) check("baseline_hold", {20'd0, baseline}, {20'd0, hold_exp});
        end
        prev_comp = comp;
    end

    task automatic fill_const(input int v);
        for (int i = 0; i < NSAMP; i++) cur[i] = v;
    endtask

    task automatic fill_alt(input int a, input int b);
        for (int i = 0; i < NSAMP; i++) cur[i] = (i % 2 == 0) ? a : b;
    endtask

    task automatic fill_rand();
        for (int i = 0; i < NSAMP; i++) cur[i] = int'($urandom_range(4095)) - 2048;
    endtask

    function automatic logic [127:0] make_beat(input int b);
        logic [127:0] d;
        logic [11:0]  s;
        logic [3:0]   pad;
        for (int j = 0; j < SPB; j++) begin
            s   = 12'(cur[b*SPB+j]);
            pad = 4'($urandom);
            d[16*j +: 16] = {s, pad};
        end
        return d;
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_beat(input logic [127:0] d);
        int waited = 0;
        tvalid = 1'b1;
        tdata  = d;
        while (!tready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!tready) check("tready_timeout", 0, 1);
        @(negedge clk);
    endtask

    // gap_mode: 0 none, 1 one idle cycle before beats 1..3, 2 random idles.
    task automatic run_cur(input int gap_mode, input bit poke_recalc);
        int sum = 0;
        int expv;
        int acc0, rise0, tr0, ngaps, waited, ng;
        for (int i = 0; i < NSAMP; i++) sum += cur[i];
        expv = sum / NSAMP;
        if ((sum % NSAMP) != 0 && sum < 0) expv--;
        sb.push_back(12'(expv));
        acc0 = accepts;
        rise0 = rises;
        tr0 = tready_cycles;
        ngaps = 0;
        for (int b = 0; b < NBEATS; b++) begin
            ng = 0;
            if (gap_mode == 1 && b > 0) ng = 1;
            if (gap_mode == 2) ng = ($urandom_range(3) == 0) ? int'($urandom_range(2)) + 1 : 0;
            for (int g = 0; g < ng; g++) begin
                tvalid = 1'b0;
                tdata  = {$urandom, $urandom, $urandom, $urandom};
                if (poke_recalc && b == 2) recalc = 1'b1;
                @(negedge clk);
                recalc = 1'b0;
                ngaps++;
            end
            send_beat(make_beat(b));
        end
        tvalid = 1'b0;
        waited = 0;
        while (rises == rise0 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("comp_seen", rises != rise0, 1);
        check("beats_accepted", accepts - acc0, NBEATS);
        check("tready_cycles", tready_cycles - tr0, NBEATS + ngaps);
        // Valid data in DONE must not be taken.
        acc0 = accepts;
        tvalid = 1'b1;
        tdata = {$urandom, $urandom, $urandom, $urandom};
        repeat (3) @(negedge clk);
        tvalid = 1'b0;
        check("no_accept_in_done", accepts - acc0, 0);
        check("comp_held", comp, 1);
        last_expected = expv;
    endtask

    task automatic start_recalc();
        hold_exp = 12'(last_expected);
        recalc = 1'b1;
        @(negedge clk);
        recalc = 1'b0;
        check("recalc_comp_drop", comp, 0);
        check("recalc_baseline_keep", {20'd0, baseline}, {20'd0, hold_exp});
        hold_valid = 1'b1;
    endtask

    initial begin
        rst_n  = 1'b0;
        tvalid = 1'b0;
        tdata  = '0;
        recalc = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_tready", tready, 0);
        check("rst_comp", comp, 0);
        check("rst_baseline", {20'd0, baseline}, 0);
        #2 rst_n = 1'b1;
        @(negedge clk);

        fill_const(100);       run_cur(0, 1'b0);
        start_recalc(); fill_alt(10, 11);   run_cur(0, 1'b0);
        start_recalc(); fill_alt(-1, -2);   run_cur(0, 1'b0);
        start_recalc(); fill_const(-5);     run_cur(0, 1'b0);
        start_recalc(); fill_const(2047);   run_cur(0, 1'b0);
        start_recalc(); fill_const(-2048);  run_cur(0, 1'b0);
        start_recalc(); fill_const(100);    run_cur(1, 1'b1);
        start_recalc(); fill_const(50);     run_cur(0, 1'b0);
        for (int r = 0; r < 5; r++) begin
            start_recalc(); fill_rand(); run_cur(2, 1'b0);
        end

        // Abort a calculation after two beats with reset.
        start_recalc();
        fill_rand();
        send_beat(make_beat(0));
        send_beat(make_beat(1));
        tvalid = 1'b0;
        hold_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("midrst_tready", tready, 0);
        check("midrst_comp", comp, 0);
        check("midrst_baseline", {20'd0, baseline}, 0);
        @(negedge clk);
        @(negedge clk);
        check("midrst_hold_comp", comp, 0);
        #2 rst_n = 1'b1;
        @(negedge clk);
        fill_const(7);
        run_cur(0, 1'b0);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, want finish before timeout");
        $fatal(1, "watchdog");
    end

endmodule
